// File: rtl/datamemo_arbiter_pkg.sv
// Shared types for the data-memory arbiter slice.
//   bus_type     : 32-bit data/address bus word
//   dm_state_t   : transaction sequencer states (accept / access / respond)
//   dm_req_id_t  : requester identity, CPU or DMA
//   DM_LAST_ADDR : highest legal word base address of the 97-byte memory
package types;

  typedef logic [31:0] bus_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dm_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } dm_req_id_t;

  localparam bus_type DM_LAST_ADDR = 32'd93;

  // Unsigned full-width range check; unaligned addresses are legal.
  function automatic logic dm_addr_out_of_range(input bus_type addr, input bus_type last_addr);
    return (addr > last_addr);
  endfunction

endpackage

// File: rtl/datamemo_arbiter_rr.sv
// Two-input round-robin picker for the data-memory arbiter.
//   clk, reset  : clock, synchronous active-high reset
//   req[1:0]    : bit 0 = CPU request, bit 1 = DMA request
//   fixed_prio  : 1 = CPU always wins a tie
//   advance     : commit the current grant as the new last_grant
//   grant[1:0]  : one-hot (or zero) combinational grant
module rr_arbiter2
  import types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  logic       advance,
  output logic [1:0] grant
);

  dm_req_id_t last_grant_q;
  dm_req_id_t last_grant_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      // Tie: the requester that did not win last time goes first.
      2'b11: grant = (fixed_prio || (last_grant_q == REQ_DMA)) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance && (grant != 2'b00)) begin
      last_grant_d = grant[1] ? REQ_DMA : REQ_CPU;
    end
  end

  // Reset to DMA so that the CPU takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= REQ_DMA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/datamemo_arbiter.sv
// Two-requester arbiter and sequencer for the byte-addressed 32-bit data
// memory. Each transaction runs accept (IDLE) -> ACCESS -> RESP.
//   clk, reset                : clock, synchronous active-high reset
//   cpu_req_* / dma_req_*     : request valid, write, addr, wdata; ready out
//   cpu_rsp_valid/dma_rsp_valid : one-cycle response pulse per requester
//   rsp_rdata, rsp_error      : shared response data and out-of-range flag
//   mem_*                     : memory address, write data, enables, read data
module datamemo_arbiter
  import types::*;
#(
  parameter bus_type MEM_LAST_ADDR  = DM_LAST_ADDR,
  parameter bit      CPU_FIXED_PRIO = 1'b0
)
(
  input  logic    clk,
  input  logic    reset,
  input  logic    cpu_req_valid,
  input  logic    cpu_req_write,
  input  bus_type cpu_req_addr,
  input  bus_type cpu_req_wdata,
  output logic    cpu_req_ready,
  output logic    cpu_rsp_valid,
  input  logic    dma_req_valid,
  input  logic    dma_req_write,
  input  bus_type dma_req_addr,
  input  bus_type dma_req_wdata,
  output logic    dma_req_ready,
  output logic    dma_rsp_valid,
  output bus_type rsp_rdata,
  output logic    rsp_error,
  output bus_type mem_address,
  output bus_type mem_input_data,
  output logic    mem_enable_read,
  output logic    mem_enable_write,
  input  bus_type mem_read_data
);

  dm_state_t  state_q, state_d;
  logic       err_q, err_d;
  bus_type    rsp_rdata_q, rsp_rdata_d;
  logic       lat_write_q, lat_write_d;
  bus_type    lat_addr_q, lat_addr_d;
  bus_type    lat_wdata_q, lat_wdata_d;
  dm_req_id_t lat_id_q, lat_id_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       advance;
  bus_type    sel_addr;

  // Requests are only offered to the picker when a new transaction can start.
  assign req     = {dma_req_valid, cpu_req_valid} & {2{(state_q == IDLE) && !reset}};
  assign advance = |grant;
  assign sel_addr = grant[1] ? dma_req_addr : cpu_req_addr;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .fixed_prio(CPU_FIXED_PRIO),
    .advance   (advance),
    .grant     (grant)
  );

  always_comb begin
    state_d          = state_q;
    err_d            = err_q;
    rsp_rdata_d      = rsp_rdata_q;
    lat_write_d      = lat_write_q;
    lat_addr_d       = lat_addr_q;
    lat_wdata_d      = lat_wdata_q;
    lat_id_d         = lat_id_q;
    cpu_req_ready    = grant[0];
    dma_req_ready    = grant[1];
    cpu_rsp_valid    = 1'b0;
    dma_rsp_valid    = 1'b0;
    mem_address      = '0;
    mem_input_data   = '0;
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          lat_write_d = grant[1] ? dma_req_write : cpu_req_write;
          lat_addr_d  = sel_addr;
          lat_wdata_d = grant[1] ? dma_req_wdata : cpu_req_wdata;
          lat_id_d    = grant[1] ? REQ_DMA : REQ_CPU;
          err_d       = dm_addr_out_of_range(sel_addr, MEM_LAST_ADDR);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (!err_q) begin
          mem_address      = lat_addr_q;
          mem_input_data   = lat_wdata_q;
          // Gated by reset so an aborted write never reaches the memory.
          mem_enable_write = lat_write_q && !reset;
          mem_enable_read  = !lat_write_q && !reset;
          rsp_rdata_d      = lat_write_q ? '0 : mem_read_data;
        end else begin
          rsp_rdata_d = '0;
        end
        state_d = RESP;
      end
      RESP: begin
        cpu_rsp_valid = (lat_id_q == REQ_CPU);
        dma_rsp_valid = (lat_id_q == REQ_DMA);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = (state_q == RESP) && err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Request latch: only consumed in ACCESS/RESP, so it needs no reset.
  always_ff @(posedge clk) begin
    lat_write_q <= lat_write_d;
    lat_addr_q  <= lat_addr_d;
    lat_wdata_q <= lat_wdata_d;
    lat_id_q    <= lat_id_d;
  end

endmodule

// File: tb/tb_datamemo_arbiter.sv
module tb_datamemo_arbiter;
  import types::*;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  bit      mon_en = 1'b0;

  logic    cpu_req_valid = 0, cpu_req_write = 0;
  bus_type cpu_req_addr = '0, cpu_req_wdata = '0;
  logic    dma_req_valid = 0, dma_req_write = 0;
  bus_type dma_req_addr = '0, dma_req_wdata = '0;
  logic    cpu_req_ready, cpu_rsp_valid, dma_req_ready, dma_rsp_valid;
  bus_type rsp_rdata, mem_address, mem_input_data;
  logic    rsp_error, mem_enable_read, mem_enable_write;
  bus_type mem_read_data;

  // Second instance with fixed CPU priority; its memory always reads 0.
  logic    f_cpu_valid = 0, f_dma_valid = 0;
  logic    f_cpu_ready, f_cpu_rsp, f_dma_ready, f_dma_rsp, f_err, f_re, f_we;
  bus_type f_rdata, f_maddr, f_mdata;
  bus_type f_mem_rdata = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  datamemo_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid),
    .dma_req_valid(dma_req_valid), .dma_req_write(dma_req_write),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_req_ready(dma_req_ready), .dma_rsp_valid(dma_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_read_data(mem_read_data)
  );

  datamemo_arbiter #(.CPU_FIXED_PRIO(1'b1)) dut_fixed (
    .clk(clk), .reset(reset),
    .cpu_req_valid(f_cpu_valid), .cpu_req_write(1'b0),
    .cpu_req_addr(32'h0), .cpu_req_wdata(32'h0),
    .cpu_req_ready(f_cpu_ready), .cpu_rsp_valid(f_cpu_rsp),
    .dma_req_valid(f_dma_valid), .dma_req_write(1'b0),
    .dma_req_addr(32'h4), .dma_req_wdata(32'h0),
    .dma_req_ready(f_dma_ready), .dma_rsp_valid(f_dma_rsp),
    .rsp_rdata(f_rdata), .rsp_error(f_err),
    .mem_address(f_maddr), .mem_input_data(f_mdata),
    .mem_enable_read(f_re), .mem_enable_write(f_we),
    .mem_read_data(f_mem_rdata)
  );

  // Byte-addressed memory (bytes 0..96), little-endian, combinational read.
  logic [7:0] mem_b [0:96];
  logic [7:0] sh_b  [0:96];

  initial begin
    for (int i = 0; i <= 96; i++) begin
      mem_b[i] = 8'(i * 7 + 3);
      sh_b[i]  = 8'(i * 7 + 3);
    end
  end

  always_comb begin
    mem_read_data = '0;
    if (mem_address <= 32'd93)
      mem_read_data = {mem_b[mem_address + 3], mem_b[mem_address + 2],
                       mem_b[mem_address + 1], mem_b[mem_address]};
  end

  always @(posedge clk) begin
    if (mem_enable_write && mem_address <= 32'd93) begin
      for (int k = 0; k < 4; k++) mem_b[mem_address + k] <= mem_input_data[8*k +: 8];
    end
  end

  function automatic bus_type sh_rd(input bus_type a);
    return {sh_b[a + 3], sh_b[a + 2], sh_b[a + 1], sh_b[a]};
  endfunction

  // Scoreboard
  typedef struct {
    dm_req_id_t id;
    bus_type    rdata;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t       sb_q [$];
  dm_req_id_t grant_q [$];
  bus_type    last_rdata = '0;
  logic       last_err = 1'b0;

  bit         pend_v = 0;
  logic       pend_w, pend_err;
  bus_type    pend_a, pend_d;
  dm_req_id_t pend_id;
  int         pend_cyc;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cpu_rsp_valid || dma_rsp_valid) begin
          checks++;
          if (cpu_rsp_valid && dma_rsp_valid) begin
            errors++; $display("FAIL rsp_both: cpu=%b dma=%b required one", cpu_rsp_valid, dma_rsp_valid);
          end else if (sb_q.size() == 0) begin
            errors++; $display("FAIL rsp_unexpected: cyc=%0d cpu=%b dma=%b required none", cyc, cpu_rsp_valid, dma_rsp_valid);
          end else begin
            exp_t e;
            dm_req_id_t got;
            e   = sb_q.pop_front();
            got = dma_rsp_valid ? REQ_DMA : REQ_CPU;
            if (got !== e.id || rsp_rdata !== e.rdata || rsp_error !== e.err || cyc != e.cyc + 2) begin
              errors++;
              $display("FAIL rsp: id=%0d rdata=%h err=%b cyc=%0d required id=%0d rdata=%h err=%b cyc=%0d",
                       got, rsp_rdata, rsp_error, cyc, e.id, e.rdata, e.err, e.cyc + 2);
            end
            last_rdata = rsp_rdata;
            last_err   = rsp_error;
          end
        end
        if (pend_v) begin
          checks++;
          if (reset) begin
            if (mem_enable_write !== 1'b0 || mem_enable_read !== 1'b0) begin
              errors++; $display("FAIL abort_mem: we=%b re=%b required 0 0", mem_enable_write, mem_enable_read);
            end
          end else begin
            exp_t e;
            logic ewe, ere;
            ewe = pend_w && !pend_err;
            ere = !pend_w && !pend_err;
            if (mem_enable_write !== ewe || mem_enable_read !== ere ||
                (!pend_err && mem_address !== pend_a) || (ewe && mem_input_data !== pend_d)) begin
              errors++;
              $display("FAIL access: we=%b re=%b addr=%h wd=%h required we=%b re=%b addr=%h wd=%h",
                       mem_enable_write, mem_enable_read, mem_address, mem_input_data, ewe, ere, pend_a, pend_d);
            end
            e.id    = pend_id;
            e.err   = pend_err;
            e.cyc   = pend_cyc;
            e.rdata = ere ? sh_rd(pend_a) : 32'h0;
            if (ewe) for (int k = 0; k < 4; k++) sh_b[pend_a + k] = pend_d[8*k +: 8];
            sb_q.push_back(e);
          end
          pend_v = 0;
        end else if (!reset) begin
          checks++;
          if (mem_enable_read !== 1'b0 || mem_enable_write !== 1'b0 || mem_address !== 32'h0 || mem_input_data !== 32'h0) begin
            errors++;
            $display("FAIL idle_mem: re=%b we=%b addr=%h wd=%h required all 0", mem_enable_read, mem_enable_write, mem_address, mem_input_data);
          end
        end
        if (!reset && ((cpu_req_valid && cpu_req_ready) || (dma_req_valid && dma_req_ready))) begin
          checks++;
          if (cpu_req_ready && dma_req_ready) begin
            errors++; $display("FAIL ready_both: cpu=%b dma=%b required one", cpu_req_ready, dma_req_ready);
          end
          pend_v   = 1;
          pend_id  = dma_req_ready ? REQ_DMA : REQ_CPU;
          pend_w   = dma_req_ready ? dma_req_write : cpu_req_write;
          pend_a   = dma_req_ready ? dma_req_addr : cpu_req_addr;
          pend_d   = dma_req_ready ? dma_req_wdata : cpu_req_wdata;
          pend_err = (pend_a > 32'd93);
          pend_cyc = cyc;
          grant_q.push_back(pend_id);
        end
      end
    end
  end

  task automatic cpu_do(input logic w, input bus_type a, input bus_type d);
    int n = 0;
    cpu_req_valid = 1; cpu_req_write = w; cpu_req_addr = a; cpu_req_wdata = d;
    @(negedge clk);
    while (!cpu_req_ready && n < 20) begin @(negedge clk); n++; end
    if (!cpu_req_ready) begin
      errors++; $display("FAIL cpu_ready_timeout: ready=%b required 1", cpu_req_ready);
    end
    @(posedge clk); #1;
    cpu_req_valid = 0;
  endtask

  task automatic dma_do(input logic w, input bus_type a, input bus_type d);
    int n = 0;
    dma_req_valid = 1; dma_req_write = w; dma_req_addr = a; dma_req_wdata = d;
    @(negedge clk);
    while (!dma_req_ready && n < 20) begin @(negedge clk); n++; end
    if (!dma_req_ready) begin
      errors++; $display("FAIL dma_ready_timeout: ready=%b required 1", dma_req_ready);
    end
    @(posedge clk); #1;
    dma_req_valid = 0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    cpu_req_valid = 1; dma_req_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_req_ready, dma_req_ready, cpu_rsp_valid, dma_rsp_valid, mem_enable_read, mem_enable_write, rsp_error} !== 7'b0 ||
        rsp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_input_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b%b rsp=%b%b re=%b we=%b err=%b rdata=%h addr=%h wd=%h required all 0",
               cpu_req_ready, dma_req_ready, cpu_rsp_valid, dma_rsp_valid, mem_enable_read, mem_enable_write,
               rsp_error, rsp_rdata, mem_address, mem_input_data);
    end
    @(posedge clk); #1;
    cpu_req_valid = 0; dma_req_valid = 0;
    reset = 0;
    mon_en = 1;
  endtask

  task automatic test_write_read();
    cpu_do(1'b1, 32'h10, 32'hDEADBEEF);
    settle();
    cpu_do(1'b0, 32'h10, 32'h0);
    settle();
    checks++;
    if (last_rdata !== 32'hDEADBEEF || last_err !== 1'b0) begin
      errors++; $display("FAIL write_read: rdata=%h err=%b required DEADBEEF 0", last_rdata, last_err);
    end
  endtask

  task automatic test_error();
    dma_do(1'b0, 32'd94, 32'h0);
    settle();
    checks++;
    if (last_rdata !== 32'h0 || last_err !== 1'b1) begin
      errors++; $display("FAIL dma_oor: rdata=%h err=%b required 0 1", last_rdata, last_err);
    end
    cpu_do(1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA);
    settle();
    cpu_do(1'b0, 32'd93, 32'h0);
    settle();
    checks++;
    if (last_err !== 1'b0) begin
      errors++; $display("FAIL last_legal: err=%b required 0", last_err);
    end
  endtask

  task automatic test_unaligned();
    cpu_do(1'b1, 32'h05, 32'hAABBCCDD);
    settle();
    dma_do(1'b0, 32'h05, 32'h0);
    settle();
    checks++;
    if (last_rdata !== 32'hAABBCCDD) begin
      errors++; $display("FAIL unaligned_5: rdata=%h required AABBCCDD", last_rdata);
    end
    cpu_do(1'b0, 32'h04, 32'h0);
    settle();
    checks++;
    if (last_rdata !== 32'hBBCCDD1F) begin
      errors++; $display("FAIL unaligned_4: rdata=%h required BBCCDD1F", last_rdata);
    end
  endtask

  task automatic test_reset_abort();
    cpu_do(1'b1, 32'h20, 32'h12345678);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    settle();
    cpu_do(1'b0, 32'h20, 32'h0);
    settle();
    checks++;
    if (last_rdata !== 32'hF8F1EAE3) begin
      errors++; $display("FAIL reset_abort: rdata=%h required F8F1EAE3", last_rdata);
    end
  endtask

  task automatic cpu_seq(input int n);
    for (int i = 0; i < n; i++) cpu_do(1'b1, 32'h30 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
  endtask

  task automatic dma_seq(input int n);
    for (int i = 0; i < n; i++) dma_do(1'b0, 32'h30 + 32'(4 * i), 32'h0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    grant_q.delete();
    fork
      cpu_seq(4);
      dma_seq(4);
    join
    settle();
    checks++;
    if (grant_q.size() != 8) begin
      errors++; $display("FAIL rr_count: grants=%0d required 8", grant_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        dm_req_id_t exp_id;
        exp_id = (i % 2 == 0) ? REQ_CPU : REQ_DMA;
        checks++;
        if (grant_q[i] !== exp_id) begin
          errors++; $display("FAIL rr_order: idx=%0d grant=%0d required %0d", i, grant_q[i], exp_id);
        end
      end
    end
  endtask

  task automatic test_fixed_prio();
    int n_cpu = 0;
    int last_acc = 0;
    int dma_cyc = -1;
    f_cpu_valid = 1; f_dma_valid = 1;
    for (int c = 0; c < 200 && n_cpu < 20; c++) begin
      @(negedge clk);
      checks++;
      if (f_dma_ready !== 1'b0) begin
        errors++; $display("FAIL fixed_dma_granted: cyc=%0d ready=%b required 0", cyc, f_dma_ready);
      end
      if (f_cpu_ready === 1'b1) begin n_cpu++; last_acc = cyc; end
      @(posedge clk); #1;
    end
    f_cpu_valid = 0;
    checks++;
    if (n_cpu != 20) begin
      errors++; $display("FAIL fixed_cpu_count: got=%0d required 20", n_cpu);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (f_dma_ready === 1'b1) begin dma_cyc = cyc; break; end
    end
    checks++;
    if (dma_cyc != last_acc + 3) begin
      errors++; $display("FAIL fixed_dma_grant: cyc=%0d required %0d", dma_cyc, last_acc + 3);
    end
    @(posedge clk); #1;
    f_dma_valid = 0;
    settle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_error();
    test_unaligned();
    test_reset_abort();
    test_back_to_back();
    test_fixed_prio();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: entries=%0d required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time=%0t required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
